// File: rtl/mux_nx1_rr_pkg.sv
// Shared select-mode encodings and the modulo-N pointer increment for the N:1 mux.
// Pure declarations; no latency or flow-control behaviour of its own.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // N need not be a power of two, so the wrap is an explicit compare, not a bit-width overflow.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping modulo N.
// Zero latency; no backpressure of its own (the caller qualifies the grant with its load enable).
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] idx;

  // Walking from the farthest offset down lets the closest requester to ptr win last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (sum >= (SEL_W + 1)'(N)) begin
        sum = sum - (SEL_W + 1)'(N);
      end
      idx = sum[SEL_W-1:0];
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 valid/ready mux, fixed or round-robin select, into a single output register (1-cycle latency).
// Output refills in the same cycle it drains; with out_valid=1 and out_ready=0 everything holds and in_ready=0.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             xfer;
  logic             fix_vld;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [W-1:0]     mux_dat;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Matching sel against each legal index doubles as the sel < N range check.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        fix_vld = in_valid[i];
      end
    end
  end

  always_comb begin
    gnt_vld = fix_vld;
    gnt_idx = sel;
    if (mode == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end
  end

  assign load = ~out_valid_q | out_ready;
  assign xfer = load & gnt_vld & ~rst;

  always_comb begin
    in_ready = '0;
    mux_dat  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        mux_dat     = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = mux_dat;
        out_sel_d  = gnt_idx;
        if (mode == MODE_RR) begin
          ptr_d = SEL_W'(wrap_inc(32'(gnt_idx), N));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

  a_in_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr (N=4, W=8): vector table with hand-derived grants, plus a beat scoreboard.
module tb_mux_nx1_rr;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic [SEL_W-1:0] out_sel;
  logic             out_ready;

  always #5 clk = ~clk;

  mux_nx1_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct {
    logic             rst;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     iv;
    logic             ordy;
    logic [N-1:0]     exp_ir;
    logic             exp_ov;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]     dat;
    logic [SEL_W-1:0] sel;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ch_data(input int ch, input int idx);
    return W'(((idx * 4) + ch) ^ 32'h5A);
  endfunction

  function automatic int oh_idx(input logic [N-1:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic add(input logic r, input logic m, input logic [SEL_W-1:0] s, input logic [N-1:0] iv,
                     input logic ordy, input logic [N-1:0] ir, input logic ov);
    vecs.push_back('{r, m, s, iv, ordy, ir, ov});
  endtask

  task automatic drive(input vec_t v, input int idx);
    rst       = v.rst;
    mode      = v.mode;
    sel       = v.sel;
    in_valid  = v.iv;
    out_ready = v.ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = ch_data(i, idx);
  endtask

  initial begin
    beat_t exp_b;

    //    rst  mode sel   in_valid ordy exp_in_ready exp_out_valid
    // fixed mode: sel=2 then sel=3 with ch3 idle
    add(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b0);  // 0
    add(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1);  // 1
    add(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1);  // 2
    add(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b1);  // 3
    add(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0);  // 4
    // round-robin fairness 0,1,3,0,1,3 with ch2 idle
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b0001, 1'b0);  // 5
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b0010, 1'b1);  // 6
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b1000, 1'b1);  // 7
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1);  // 8
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b0010, 1'b1);  // 9
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b1000, 1'b1);  // 10
    // backpressure for 3 cycles, then drain+refill with no bubble
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b0, 4'b0000, 1'b1);  // 11
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b0, 4'b0000, 1'b1);  // 12
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b0, 4'b0000, 1'b1);  // 13
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1);  // 14
    add(1'b0, 1'b1, 2'd0, 4'b1011, 1'b1, 4'b0010, 1'b1);  // 15 ptr -> 2
    // mode switch: fixed sel=0, then rr resumes from ch2
    add(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);  // 16
    add(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);  // 17
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1);  // 18
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1);  // 19
    // mid-stream reset under backpressure
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);  // 20 ptr -> 1
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1);  // 21
    add(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1);  // 22
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);  // 23
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1);  // 24
    add(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);  // 25
    add(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);  // 26
    // reset while load is open: no in_ready during the reset cycle, ptr back to 0
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b0);  // 27 ptr -> 3
    add(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b1);  // 28
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b0);  // 29
    add(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1);  // 30
    add(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);  // 31
    add(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);  // 32

    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = ch_data(i, 99);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_sel", 32'(out_sel), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v], v);
      @(negedge clk);
      check($sformatf("v%0d in_ready", v), 32'(in_ready), 32'(vecs[v].exp_ir));
      check($sformatf("v%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
      if (out_valid === 1'b1) begin
        check($sformatf("v%0d unexpected beat", v), 32'(sb.size() == 0), 32'd0);
        if (sb.size() > 0) begin
          exp_b = sb[0];
          check($sformatf("v%0d out_data", v), 32'(out_data), 32'(exp_b.dat));
          check($sformatf("v%0d out_sel", v), 32'(out_sel), 32'(exp_b.sel));
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (vecs[v].exp_ir != '0) begin
        sb.push_back('{ch_data(oh_idx(vecs[v].exp_ir), v), SEL_W'(oh_idx(vecs[v].exp_ir))});
      end
      if (vecs[v].rst) sb.delete();
      @(posedge clk);
      #1;
    end

    // fixed sel=2 carrying 8'hA5, then sel=3 with ch3 idle: output drops, data/sel hold
    rst       = 1'b0;
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = {8'h3C, 8'hA5, 8'h11, 8'h22};
    @(negedge clk);
    check("a5 in_ready", 32'(in_ready), 32'h4);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("a5 out_valid", 32'(out_valid), 32'd1);
    check("a5 out_data", 32'(out_data), 32'hA5);
    check("a5 out_sel", 32'(out_sel), 32'd2);
    sel      = 2'd3;
    in_valid = 4'b0111;
    #1;
    check("sel3 in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("sel3 out_valid", 32'(out_valid), 32'd0);
    check("sel3 out_data hold", 32'(out_data), 32'hA5);
    check("sel3 out_sel hold", 32'(out_sel), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two select modes:
  - fixed: an external select picks the channel.
  - round-robin: the block rotates fairly over the channels that have data.
- One-cycle registered output stage, so it can sit between producer lanes and a single shared consumer in the datapath.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel (1..64).
- SEL_W, $clog2(N), width of select and source-index fields; derived, not overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  channel i has a beat offered.
- in_ready  output  N  channel i beat accepted this cycle (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  W  registered selected data.
- out_valid  output  1  out_data holds a beat.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset, on the clk edge with rst=1:
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ready is all 0 while rst=1.
- Load enable: load = ~out_valid | out_ready. When the output stage drains, it refills in the same cycle, giving full throughput of 1 beat/cycle.
- Grant, combinational:
  - Fixed mode: grant = sel if sel < N and in_valid[sel]=1; otherwise no grant. Other channels are never granted, even if valid.
  - Round-robin mode: grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo N. No grant if in_valid is all 0.
- in_ready[i] = load & (grant == i) & grant_exists. At most one bit is set per cycle.
- On a clk edge with a transfer (load & grant_exists):
  - out_data <= channel data.
  - out_sel <= grant.
  - out_valid <= 1.
  - In round-robin mode, ptr <= grant+1, wrapping N-1 -> 0.
- On a clk edge with load and no grant: out_valid <= 0; out_data and out_sel hold their values.
- On a clk edge with out_valid=1 & out_ready=0: all output registers hold. out_data must not change while out_valid=1 and out_ready=0.
- Latency: a beat accepted at edge k appears at out_* after edge k and is consumed at the first later edge with out_ready=1.
- ptr does not move in fixed mode. Switching mode takes effect on the next grant evaluation, and ptr resumes from its retained value.
- sel or mode changing while out_valid is held has no effect on the held beat.
- Reset asserted mid-transfer: the pending beat is discarded, and no in_ready is asserted during that cycle.
- Non-power-of-two N: pointer wrap and the sel range check use N, not 2^SEL_W.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - A function for the wrap-increment modulo N.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; outputs gnt_idx, gnt_vld. It is purely combinational.
- mux_nx1_rr holds:
  - the output register and ptr;
  - the fixed/rr grant select;
  - the data mux.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. After release (out_ready=1), the first beat appears 1 cycle later.
- Fixed mode, N=4, W=8: sel=2, in_data ch2=8'hA5, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100 every cycle; out_data=8'hA5, out_sel=2. sel=3 with in_valid[3]=0 -> no grant, out_valid drops to 0.
- Round-robin fairness: in_valid=4'b1011, out_ready=1, ptr=0 -> grant order 0,1,3,0,1,3. Channel 2 is never granted, and the ptr wrap 3->0 is verified.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_sel stable, in_ready=0. out_ready=1 -> the held beat is consumed and the next beat loads in the same cycle, with no bubble.
- Mode switch: in rr mode after a grant to ch1 (ptr=2), switch to fixed with sel=0, then back to rr -> fixed grants only ch0 and ptr stays 2. The next rr grant starts the search at ch2.
- Mid-stream reset: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and ptr=0, and the discarded beat never appears.
